// File: rtl/alu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl
//  Purpose  : Multi-cycle issue-side controller for the 8-bit ALU. It fetches
//             16-bit instructions over a req/ack port and decodes them into
//             ALU operands. It captures the ALU result and flags, then either
//             writes the result back to a 4x8 register file or resolves a
//             branch.
//  Options  : ALU_CTRL_TIMEOUT_EN adds a fetch-wait watchdog. After TIMEOUT
//             FETCH cycles without ack, the core halts and raises err.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl #(
    parameter logic [7:0] PC_RESET = 8'd0
`ifdef ALU_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [3:0]  alu_func,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags,
    output logic        retire,
    output logic        halted
`ifdef ALU_CTRL_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    // Opcode / ALU function codes shared with the ALU
    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_MUL = 4'd2;
    localparam logic [3:0] c_OP_DIV = 4'd3;
    localparam logic [3:0] c_OP_LDI = 4'd4;
    localparam logic [3:0] c_OP_BNE = 4'd5;
    localparam logic [3:0] c_OP_BEQ = 4'd6;
    localparam logic [3:0] c_OP_MOV = 4'd7;
    localparam logic [3:0] c_OP_NA  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;
    logic [7:0]  r_res;
    logic        r_flg0;
    logic [3:0]  r_func;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_retire;
    logic        r_halted;
    logic [7:0]  r_regs [4];

    // Instruction fields of the latched instruction word
    logic [3:0]  w_op;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [7:0]  w_imm;

    assign w_op  = r_ir[15:12];
    assign w_rd  = r_ir[11:10];
    assign w_rs  = r_ir[9:8];
    assign w_imm = r_ir[7:0];

    // Only the branch condition bit of the ALU flags drives control flow
    logic w_unused_flags;
    assign w_unused_flags = ^alu_flags[3:1];

`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [c_WAIT_W-1:0] r_wait;
    logic                r_err;

    assign err = r_err;
`endif

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign alu_func  = r_func;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign retire    = r_retire;
    assign halted    = r_halted;

    // Control FSM: fetch, decode, execute and write-back with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_pc     <= PC_RESET;
            r_ir     <= 16'd0;
            r_res    <= 8'd0;
            r_flg0   <= 1'b0;
            r_func   <= c_OP_NA;
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_retire <= 1'b0;
            r_halted <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'd0;
            end
`ifdef ALU_CTRL_TIMEOUT_EN
            r_wait   <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Any ack seen here belongs to a fetch abandoned by reset
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
`ifdef ALU_CTRL_TIMEOUT_EN
                    r_wait  <= '0;
`endif
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end
`ifdef ALU_CTRL_TIMEOUT_EN
                    else if (r_wait == c_WAIT_LAST) begin
                        r_req    <= 1'b0;
                        r_halted <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
`endif
                end
                S_DECODE: begin
                    r_func  <= w_op[3] ? c_OP_NA : w_op;
                    r_a     <= r_regs[w_rd];
                    r_b     <= (w_op == c_OP_LDI) ? w_imm : r_regs[w_rs];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res   <= alu_result;
                    r_flg0  <= alu_flags[0];
                    r_state <= S_WB;
                end
                S_WB: begin
                    if (w_op == c_OP_NA) begin
                        // HALT keeps PC pointing at the halting instruction
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_retire <= 1'b1;
                        r_req    <= 1'b1;
                        r_state  <= S_FETCH;
`ifdef ALU_CTRL_TIMEOUT_EN
                        r_wait   <= '0;
`endif
                        case (w_op)
                            c_OP_ADD, c_OP_SUB, c_OP_MUL, c_OP_DIV,
                            c_OP_LDI, c_OP_MOV: begin
                                r_regs[w_rd] <= r_res;
                                r_pc         <= r_pc + 8'd1;
                            end
                            // Branch is taken when the ALU reports condition bit 0 clear
                            c_OP_BNE, c_OP_BEQ: begin
                                r_pc <= r_flg0 ? (r_pc + 8'd1) : w_imm;
                            end
                            default: begin
                                r_pc <= r_pc + 8'd1;
                            end
                        endcase
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
